uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART_tx transmitter between NUM_REQ byte requesters (status telemetry,
//  command acks, diagnostics). Round-robin arbitration with bounded bursts so one requester
//  holds the link for a multi-byte packet without starving the others. Sits between the
//  requesters and UART_tx (drives trmt/tx_data, consumes tx_done); a watchdog covers a hung UART.
// PARAMETERS
//  NUM_REQ    4      number of requesters (2..8)
//  MAX_BURST  4      max consecutive bytes per grant while another requester waits (>=1)
//  GAP_CYC    2      idle clk cycles inserted after each tx_done before next trmt (0 = none)
//  TO_CYC     65535  clk cycles waiting for tx_done before watchdog fires (16-bit counter)
// PORTS
//  clk       in   1          system clock
//  rst       in   1          asynchronous, active-high reset
//  req       in   NUM_REQ    req[i] high = requester i has a byte on req_data[i]
//  req_data  in   8*NUM_REQ  byte i at [8*i+7:8*i]; stable while req[i] is high
//  ack       out  NUM_REQ    1-cycle pulse: byte from requester i loaded into UART
//  gnt       out  NUM_REQ    one-hot current owner; all-zero when link free
//  trmt      out  1          1-cycle start pulse to UART_tx
//  tx_data   out  8          byte to UART_tx; held from trmt until next load
//  tx_done   in   1          1-cycle pulse from UART_tx at end of stop bit
//  busy      out  1          high in any state other than IDLE
//  tx_err    out  1          sticky watchdog flag; cleared by clr_err or rst
//  clr_err   in   1          synchronous clear of tx_err
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, gnt=0, ack=0, trmt=0, tx_data=8'h00, busy=0,
//   tx_err=0, rr_ptr=0, burst_cnt=0, gap_cnt=0, to_cnt=0. A byte already shifting in
//   UART_tx is not aborted; the arbiter simply restarts in IDLE.
//  States: IDLE, WAIT, GAP, ARB.
//  IDLE/ARB arbitration: winner = first i with req[i]=1 searching rr_ptr, rr_ptr+1, ...
//   wrapping mod NUM_REQ. On the same edge: gnt=onehot(winner), tx_data=req_data[winner],
//   trmt=1, ack[winner]=1, burst_cnt=1, to_cnt=0, state->WAIT. Latency req->trmt = 1 clk.
//   No req: IDLE stays; ARB clears gnt, goes IDLE.
//  ack rule: after ack[i], requester i presents next byte or drops req[i] by the next clk edge.
//  WAIT: to_cnt increments each clk. tx_done in the cycle trmt is high is ignored.
//   On tx_done: to_cnt=0; gap_cnt=0; state->GAP (GAP_CYC=0: directly to ARB).
//   to_cnt==TO_CYC-1 w/o tx_done: tx_err=1, gnt=0, rr_ptr=owner+1, state->IDLE.
//  GAP: count GAP_CYC cycles, then ARB. tx_done seen in GAP/IDLE/ARB is ignored.
//  ARB hold decision (owner o): keep if req[o]=1 AND (burst_cnt<MAX_BURST OR no other req).
//   Keep: load next byte of o (trmt, ack[o], tx_data), burst_cnt++ (saturating), gnt unchanged,
//   ->WAIT. Release: rr_ptr=(o+1) mod NUM_REQ, burst_cnt=0, then arbitrate as in IDLE
//   in this same cycle (gnt moves directly to the new owner, no zero cycle, if any req).
//  gnt/ack/trmt one-hot or zero at all times; ack[i] and trmt always coincide.
//  clr_err and watchdog firing in the same cycle: tx_err=1 (set wins).
//  req dropped by owner during WAIT/GAP: released at ARB; pending byte never acked.
// TESTING
//  1 req=4'b0001, data0=8'h67 -> next clk trmt=1, tx_data=8'h67, ack=4'b0001, gnt=4'b0001;
//    tx_done + 2 gap clks (req dropped) -> gnt=0, busy=0.
//  2 req0,req2 rise same clk, rr_ptr=0 -> req0 byte first, then req2 byte; final rr_ptr=3.
//  3 req1 holds 6 bytes A0..A5, req3 holds 1 byte B0 -> UART order A0..A3,B0,A4,A5.
//  4 req1 alone, 6 bytes -> 6 consecutive trmts, gnt=4'b0010 throughout, 2-clk gaps.
//  5 trmt issued, tx_done withheld (TO_CYC=16) -> tx_err=1 at 16th clk, gnt=0; clr_err -> 0.
//  6 rst asserted mid-WAIT (no clk edge) -> gnt,ack,trmt,busy,tx_err=0 immediately.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Bursts are bounded while others wait; a watchdog covers a UART that never finishes.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int GAP_CYC   = 2,
    parameter int TO_CYC    = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 trmt,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 tx_err,
    input  logic                 clr_err
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, GAP, ARB} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic               trmt_reg, trmt_next;
    logic [7:0]         tx_data_reg, tx_data_next;
    logic               tx_err_reg, tx_err_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [15:0]        to_cnt_reg, to_cnt_next;

    logic [7:0]         req_byte [NUM_REQ];
    logic [IDX_W-1:0]   owner, owner_inc, arb_ptr, arb_win, hi_idx, lo_idx;
    logic               others, burst_open, keep, release_now, hit_hi, hit_lo, arb_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_reg[i]) owner = IDX_W'(i);
        end
    end

    assign owner_inc   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign others      = |(req & ~gnt_reg);
    assign burst_open  = (burst_cnt_reg < BURST_W'(MAX_BURST));
    assign keep        = req[owner] && (burst_open || !others);
    assign release_now = (state_reg == ARB) && !keep;
    // On release the search starts just past the old owner in the same cycle.
    assign arb_ptr     = release_now ? owner_inc : rr_ptr_reg;

    // Lowest index at/after arb_ptr wins, else lowest index below it (wrap-around).
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i >= int'(arb_ptr)) begin
                    hit_hi = 1'b1;
                    hi_idx = IDX_W'(i);
                end else begin
                    hit_lo = 1'b1;
                    lo_idx = IDX_W'(i);
                end
            end
        end
        arb_found = hit_hi | hit_lo;
        arb_win   = hit_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        ack_next       = '0;
        trmt_next      = 1'b0;
        tx_data_next   = tx_data_reg;
        tx_err_next    = tx_err_reg & ~clr_err;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        to_cnt_next    = to_cnt_reg;

        case (state_reg)
            WAIT: begin
                // A tx_done coinciding with our own trmt belongs to an earlier byte.
                if (tx_done && !trmt_reg) begin
                    to_cnt_next  = '0;
                    gap_cnt_next = '0;
                    state_next   = (GAP_CYC == 0) ? ARB : GAP;
                end else if (to_cnt_reg == 16'(TO_CYC - 1)) begin
                    tx_err_next    = 1'b1;
                    gnt_next       = '0;
                    rr_ptr_next    = owner_inc;
                    burst_cnt_next = '0;
                    to_cnt_next    = '0;
                    state_next     = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) state_next = ARB;
                else                                    gap_cnt_next = gap_cnt_reg + 1'b1;
            end
            ARB: begin
                if (keep) begin
                    trmt_next      = 1'b1;
                    ack_next       = gnt_reg;
                    tx_data_next   = req_byte[owner];
                    burst_cnt_next = burst_open ? burst_cnt_reg + 1'b1 : burst_cnt_reg;
                    to_cnt_next    = '0;
                    state_next     = WAIT;
                end else begin
                    rr_ptr_next    = owner_inc;
                    burst_cnt_next = '0;
                    gnt_next       = '0;
                    state_next     = IDLE;
                end
            end
            default: ;
        endcase

        if ((state_reg == IDLE || release_now) && arb_found) begin
            gnt_next       = NUM_REQ'(1) << arb_win;
            ack_next       = NUM_REQ'(1) << arb_win;
            trmt_next      = 1'b1;
            tx_data_next   = req_byte[arb_win];
            burst_cnt_next = BURST_W'(1);
            to_cnt_next    = '0;
            state_next     = WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            ack_reg       <= '0;
            trmt_reg      <= 1'b0;
            tx_data_reg   <= 8'h00;
            tx_err_reg    <= 1'b0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
            to_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            ack_reg       <= ack_next;
            trmt_reg      <= trmt_next;
            tx_data_reg   <= tx_data_next;
            tx_err_reg    <= tx_err_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            to_cnt_reg    <= to_cnt_next;
        end
    end

    assign gnt     = gnt_reg;
    assign ack     = ack_reg;
    assign trmt    = trmt_reg;
    assign tx_data = tx_data_reg;
    assign tx_err  = tx_err_reg;
    assign busy    = (state_reg != IDLE);

endmodule
